// File: rtl/uwasic_spi_pwm_top.sv
// Tiny Tapeout user top: a write-only SPI register file drives 16 output
// channels. Each channel is either off, static high, or a shared PWM waveform
// (about 3 kHz from a 10 MHz clock).
module uwasic_spi_pwm_top #(
  parameter int CLK_DIV  = 12,
  parameter int NUM_REGS = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int            PW         = $clog2(CLK_DIV + 1);
  localparam logic [PW-1:0] DIV_TC     = PW'(CLK_DIV);
  localparam logic [6:0]    ADDR_LIMIT = 7'(NUM_REGS);

  // ena, uio_in and the upper ui_in bits have no function in this design.
  logic unused_inputs;
  assign unused_inputs = &{1'b0, ena, uio_in, ui_in[7:3]};

  // Two-flop synchronizers: bit 0 = SCLK, bit 1 = COPI, bit 2 = nCS.
  logic [2:0] sync_meta;
  logic [2:0] sync_q;
  logic       sclk_prev;
  logic       ncs_prev;

  // Bring the asynchronous SPI pins into the clk domain and keep the previous
  // SCLK/nCS values for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta <= 3'b000;
      sync_q    <= 3'b000;
      sclk_prev <= 1'b0;
      ncs_prev  <= 1'b0;
    end else begin
      sync_meta <= ui_in[2:0];
      sync_q    <= sync_meta;
      sclk_prev <= sync_q[0];
      ncs_prev  <= sync_q[2];
    end
  end

  logic sclk_rise;
  logic copi_s;
  logic ncs_low;
  logic ncs_fall;
  logic ncs_rise;

  assign sclk_rise = sync_q[0] & ~sclk_prev;
  assign copi_s    = sync_q[1];
  assign ncs_low   = ~sync_q[2];
  assign ncs_fall  = ~sync_q[2] & ncs_prev;
  assign ncs_rise  = sync_q[2] & ~ncs_prev;

  logic [15:0] shift_reg;
  logic [4:0]  bit_cnt;
  logic        overflow;

  // Shift COPI in MSB first on SCLK rising edges while nCS is low. The count
  // saturates at 16; any further edge marks the frame as too long so it is
  // dropped instead of committing its first 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg <= 16'h0000;
      bit_cnt   <= 5'd0;
      overflow  <= 1'b0;
    end else if (ncs_fall) begin
      shift_reg <= 16'h0000;
      bit_cnt   <= 5'd0;
      overflow  <= 1'b0;
    end else if (ncs_low && sclk_rise) begin
      if (bit_cnt == 5'd16) begin
        overflow <= 1'b1;
      end else begin
        shift_reg <= {shift_reg[14:0], copi_s};
        bit_cnt   <= bit_cnt + 5'd1;
      end
    end
  end

  logic       frame_ok;
  logic [6:0] frame_addr;
  logic [7:0] frame_data;

  assign frame_addr = shift_reg[14:8];
  assign frame_data = shift_reg[7:0];
  assign frame_ok   = ncs_rise && (bit_cnt == 5'd16) && !overflow &&
                      shift_reg[15] && (frame_addr < ADDR_LIMIT);

  logic [15:0] en_out;
  logic [15:0] en_pwm;
  logic [7:0]  duty;

  // Register file: a complete, in-range write frame updates one register on
  // the nCS rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_out <= 16'h0000;
      en_pwm <= 16'h0000;
      duty   <= 8'h00;
    end else if (frame_ok) begin
      case (frame_addr)
        7'd0:    en_out[7:0]  <= frame_data;
        7'd1:    en_out[15:8] <= frame_data;
        7'd2:    en_pwm[7:0]  <= frame_data;
        7'd3:    en_pwm[15:8] <= frame_data;
        7'd4:    duty         <= frame_data;
        default: ;
      endcase
    end
  end

  logic [PW-1:0] presc;
  logic          tick;
  logic [7:0]    pwm_cnt;

  assign tick = (presc == DIV_TC);

  // Prescaler counts 0..CLK_DIV; each wrap advances the free-running PWM
  // counter, which register writes never disturb.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc   <= '0;
      pwm_cnt <= 8'h00;
    end else begin
      if (tick) begin
        presc   <= '0;
        pwm_cnt <= pwm_cnt + 8'd1;
      end else begin
        presc <= presc + PW'(1);
      end
    end
  end

  logic        pwm_sig;
  logic [15:0] out_q;

  // 0xFF is treated as fully on so the top step is not one tick short.
  assign pwm_sig = (duty == 8'hFF) | (pwm_cnt < duty);

  // Registered channel outputs: off, static high, or the shared PWM waveform.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= 16'h0000;
    end else begin
      out_q <= en_out & (~en_pwm | {16{pwm_sig}});
    end
  end

  assign uo_out  = out_q[7:0];
  assign uio_out = out_q[15:8];
  assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_uwasic_spi_pwm_top.sv
`timescale 1ns/1ps
module tb_uwasic_spi_pwm_top;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic       sclk = 1'b0;
  logic       copi = 1'b0;
  logic       ncs = 1'b1;
  logic [7:0] ui_in;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  assign ui_in = {5'b00000, ncs, copi, sclk};

  uwasic_spi_pwm_top dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #50 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [16:0] frame;
    int          nbits;
    logic [7:0]  uo;
    logic [7:0]  uio;
  } vec_t;

  typedef struct {
    int         idx;
    logic [7:0] uo;
    logic [7:0] uio;
  } exp_t;

  vec_t vecs[12];
  exp_t sb[$];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic spi_send(input logic [16:0] f, input int nb);
    ncs = 1'b0;
    wait_clk(4);
    for (int b = nb - 1; b >= 0; b--) begin
      copi = f[b];
      wait_clk(4);
      sclk = 1'b1;
      wait_clk(4);
      sclk = 1'b0;
    end
    wait_clk(4);
    ncs = 1'b1;
    wait_clk(4);
  endtask

  task automatic wr(input logic [6:0] addr, input logic [7:0] data);
    spi_send({1'b0, 1'b1, addr, data}, 16);
  endtask

  // Counts negedge samples until uo_out[0] equals lvl.
  task automatic wait_bit(input logic lvl, input int budget, output int n, output bit ok);
    n  = 0;
    ok = 1'b0;
    while (n < budget) begin
      @(negedge clk);
      n++;
      if (uo_out[0] === lvl) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic measure(output int high, output int period, output bit ok);
    int  n;
    bit  o1, o2, o3, o4;
    wait_bit(1'b0, 5000, n, o1);
    wait_bit(1'b1, 5000, n, o2);
    wait_bit(1'b0, 5000, high, o3);
    wait_bit(1'b1, 5000, n, o4);
    period = high + n;
    ok = o1 & o2 & o3 & o4;
  endtask

  task automatic count_high(input int n, output int highs);
    highs = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (uo_out[0] === 1'b1) highs++;
    end
  endtask

  initial begin
    #10ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int   high, period, highs, freq;
    int   hi_bad, phase_bad, nh;
    bit   ok;
    exp_t e;

    vecs[0]  = '{17'h080F0, 16, 8'hF0, 8'h00};
    vecs[1]  = '{17'h081CC, 16, 8'hF0, 8'hCC};
    vecs[2]  = '{17'h00030, 16, 8'hF0, 8'hCC};
    vecs[3]  = '{17'h08555, 16, 8'hF0, 8'hCC};
    vecs[4]  = '{17'h040AA, 15, 8'hF0, 8'hCC};
    vecs[5]  = '{17'h10154, 17, 8'hF0, 8'hCC};
    vecs[6]  = '{17'h0FF00, 16, 8'hF0, 8'hCC};
    vecs[7]  = '{17'h082F0, 16, 8'h00, 8'hCC};
    vecs[8]  = '{17'h084FF, 16, 8'hF0, 8'hCC};
    vecs[9]  = '{17'h08200, 16, 8'hF0, 8'hCC};
    vecs[10] = '{17'h0800F, 16, 8'h0F, 8'hCC};
    vecs[11] = '{17'h08133, 16, 8'h0F, 8'h33};

    rst_n = 1'b0;
    wait_clk(5);
    rst_n = 1'b1;
    wait_clk(3);
    check("reset_uo", uo_out, 8'h00);
    check("reset_uio", uio_out, 8'h00);
    check("reset_oe", uio_oe, 8'hFF);

    for (int i = 0; i < 12; i++) begin
      sb.push_back('{i, vecs[i].uo, vecs[i].uio});
      spi_send(vecs[i].frame, vecs[i].nbits);
      wait_clk(8);
      e = sb.pop_front();
      check($sformatf("vec%0d_uo", e.idx), uo_out, e.uo);
      check($sformatf("vec%0d_uio", e.idx), uio_out, e.uio);
    end

    // 50% duty on channel 0
    wr(7'h00, 8'h01);
    wr(7'h01, 8'h00);
    wr(7'h02, 8'h01);
    wr(7'h03, 8'h00);
    wr(7'h04, 8'h80);
    measure(high, period, ok);
    check("pwm50_edges_seen", ok, 1);
    check_range("pwm50_high", high, 1663, 1665);
    check_range("pwm50_period", period, 3327, 3329);
    freq = (period > 0) ? 10_000_000 / period : 0;
    check_range("pwm50_freq_hz", freq, 2970, 3030);

    wr(7'h04, 8'h00);
    wait_clk(10);
    count_high(3400, highs);
    check("duty00_highs", highs, 0);

    wr(7'h04, 8'hFF);
    wait_clk(10);
    count_high(3400, highs);
    check("dutyFF_highs", highs, 3400);

    wr(7'h04, 8'h40);
    measure(high, period, ok);
    check("pwm25_edges_seen", ok, 1);
    check_range("pwm25_high", high, 831, 833);
    check_range("pwm25_period", period, 3327, 3329);

    // Mixed: upper nibble static, lower nibble PWM
    wr(7'h01, 8'hFF);
    wr(7'h03, 8'h0F);
    wr(7'h04, 8'h80);
    wait_clk(10);
    hi_bad = 0;
    phase_bad = 0;
    nh = 0;
    for (int k = 0; k < 3328; k++) begin
      @(negedge clk);
      if (uio_out[7:4] !== 4'hF) hi_bad++;
      if (uio_out[3:0] !== 4'h0 && uio_out[3:0] !== 4'hF) phase_bad++;
      if (uio_out[3:0] === 4'hF) nh++;
    end
    check("mixed_static_bad", hi_bad, 0);
    check("mixed_phase_bad", phase_bad, 0);
    check_range("mixed_pwm_highs", nh, 1663, 1665);

    // Reset in the middle of a write frame
    ncs = 1'b0;
    wait_clk(4);
    for (int b = 15; b >= 8; b--) begin
      copi = b[0] | (b == 15);
      wait_clk(4);
      sclk = 1'b1;
      wait_clk(4);
      sclk = 1'b0;
    end
    rst_n = 1'b0;
    wait_clk(2);
    check("midrst_uo", uo_out, 8'h00);
    check("midrst_uio", uio_out, 8'h00);
    check("midrst_oe", uio_oe, 8'hFF);
    ncs = 1'b1;
    copi = 1'b0;
    wait_clk(5);
    rst_n = 1'b1;
    wait_clk(20);
    check("postrst_uo", uo_out, 8'h00);
    check("postrst_uio", uio_out, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
